// File: rtl/seg_scan_driver.sv
// Seven-segment scan engine: walks NUM_DIGITS slots, overlays the team indicator, applies blank/blink.
// Latency: outputs register one cycle after each refresh tick; team strobes act on the next clk edge.
// Backpressure: none; free-running scan, inputs sampled only on tick, strobes never stall.
module seg_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int DIGIT_W      = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64,
    parameter int T_GLYPH      = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]         blank_mask,
    input  logic [NUM_DIGITS-1:0]         blink_mask,
    input  logic                          inning_over,
    input  logic                          game_over,
    input  logic                          winner,
    input  logic                          update,
    input  logic                          team_sw,
    output logic [DIGIT_W-1:0]            digit_out,
    output logic [NUM_DIGITS-1:0]         anode_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          team_view
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int PR_W  = $clog2(REFRESH_DIV);
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [IDX_W-1:0]   LAST_SLOT  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PR_W-1:0]    PR_LAST    = PR_W'(REFRESH_DIV - 1);
    localparam logic [FC_W-1:0]    FRAME_LAST = FC_W'(BLINK_FRAMES - 1);
    localparam logic [DIGIT_W-1:0] T_CODE     = DIGIT_W'(T_GLYPH);

    typedef enum logic {
        T1 = 1'b0,
        T2 = 1'b1
    } team_t;

    logic [PR_W-1:0]       prescaler;
    logic                  tick;
    logic [IDX_W-1:0]      ptr;
    logic                  frame_end;
    logic [FC_W-1:0]       frame_cnt;
    logic                  blink_phase;
    team_t                 team_q;
    team_t                 team_nxt;
    logic                  view_default;
    logic [DIGIT_W-1:0]    slot_code [NUM_DIGITS];
    logic                  slot_dark;
    logic [NUM_DIGITS-1:0] anode_nxt;

    // ---------------- refresh prescaler ----------------
    assign tick = (prescaler == PR_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PR_W'(1);
        end
    end

    // ---------------- digit pointer ----------------
    assign frame_end = tick && (ptr == LAST_SLOT);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (tick) begin
            ptr <= (ptr == LAST_SLOT) ? '0 : ptr + IDX_W'(1);
        end
    end

    // Phase flips at a frame boundary, so a blinking slot never changes mid-frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_end) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + FC_W'(1);
            end
        end
    end

    // ---------------- team view state ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            team_q <= T1;
        end else begin
            team_q <= team_nxt;
        end
    end

    always_comb begin
        team_nxt     = team_q;
        view_default = game_over ? winner : inning_over;
        case ({update, team_sw})
            2'b10:   team_nxt = team_t'(view_default);
            2'b01:   team_nxt = team_t'(~team_q);
            2'b11:   team_nxt = team_t'(~view_default);
            default: team_nxt = team_q;
        endcase
    end

    assign team_view = team_q;

    // ---------------- glyph selection ----------------
    // Top two slots are owned by the team indicator; their digits_in bits are ignored.
    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            slot_code[k] = digits_in[k*DIGIT_W +: DIGIT_W];
        end
        slot_code[NUM_DIGITS-1] = T_CODE;
        slot_code[NUM_DIGITS-2] = DIGIT_W'(team_q) + DIGIT_W'(1);
    end

    always_comb begin
        slot_dark = blank_mask[ptr] | (blink_mask[ptr] & blink_phase);
        anode_nxt = '1;
        if (!slot_dark) begin
            anode_nxt = ~(NUM_DIGITS'(1) << ptr);
        end
    end

    // ---------------- output registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            anode_n   <= '1;
            digit_out <= '0;
            digit_idx <= '0;
        end else if (tick) begin
            anode_n   <= anode_nxt;
            digit_out <= slot_code[ptr];
            digit_idx <= ptr;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomised and directed bench for seg_scan_driver against a tick-count reference model.
module tb_seg_scan_driver;

    localparam int N  = 8;
    localparam int DW = 4;
    localparam int RD = 4;
    localparam int BF = 2;
    localparam int TG = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N*DW-1:0]   digits_in = '0;
    logic [N-1:0]      blank_mask = '0;
    logic [N-1:0]      blink_mask = '0;
    logic              inning_over = 1'b0;
    logic              game_over = 1'b0;
    logic              winner = 1'b0;
    logic              update = 1'b0;
    logic              team_sw = 1'b0;
    logic [DW-1:0]     digit_out;
    logic [N-1:0]      anode_n;
    logic [2:0]        digit_idx;
    logic              team_view;

    int checks = 0;
    int failures = 0;

    // Reference model: everything derives from the number of edges since reset.
    int           m_edges = 0;
    int           m_t = 0;
    logic         m_ticked = 1'b0;
    logic [N-1:0] m_an = '1;
    logic [DW-1:0] m_dig = '0;
    logic [2:0]   m_idx = '0;
    logic         m_tv = 1'b0;

    seg_scan_driver #(
        .NUM_DIGITS(N), .DIGIT_W(DW), .REFRESH_DIV(RD), .BLINK_FRAMES(BF), .T_GLYPH(TG)
    ) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .blank_mask(blank_mask),
        .blink_mask(blink_mask), .inning_over(inning_over), .game_over(game_over),
        .winner(winner), .update(update), .team_sw(team_sw), .digit_out(digit_out),
        .anode_n(anode_n), .digit_idx(digit_idx), .team_view(team_view)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock edge, update the model from the inputs seen at that edge, settle #1.
    task automatic step();
        int  slot;
        int  ph;
        logic dflt;
        @(posedge clk);
        m_ticked = 1'b0;
        if (rst) begin
            m_edges = 0;
            m_an    = '1;
            m_dig   = '0;
            m_idx   = '0;
            m_tv    = 1'b0;
        end else begin
            m_edges++;
            if (m_edges % RD == 0) begin
                m_t   = m_edges / RD - 1;
                slot  = m_t % N;
                ph    = ((m_t / N) / BF) % 2;
                m_idx = 3'(slot);
                if (slot == N-1)      m_dig = DW'(TG);
                else if (slot == N-2) m_dig = {3'b000, m_tv} + 4'd1;
                else                  m_dig = digits_in[slot*DW +: DW];
                m_an = '1;
                if (!(blank_mask[slot] || (blink_mask[slot] && ph == 1))) m_an[slot] = 1'b0;
                m_ticked = 1'b1;
            end
            dflt = game_over ? winner : inning_over;
            if (update && team_sw) m_tv = ~dflt;
            else if (update)       m_tv = dflt;
            else if (team_sw)      m_tv = ~m_tv;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (anode_n !== 8'hFF) begin failures++; $display("FAIL reset_anode got=%h exp=ff", anode_n); end
        checks++; if (digit_out !== 4'd0) begin failures++; $display("FAIL reset_digit got=%0d exp=0", digit_out); end
        checks++; if (digit_idx !== 3'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", digit_idx); end
        checks++; if (team_view !== 1'b0) begin failures++; $display("FAIL reset_team got=%b exp=0", team_view); end
    endtask

    task automatic test_scan();
        for (int k = 0; k < 6; k++) digits_in[k*DW +: DW] = 4'(k + 1);
        blank_mask = '0;
        blink_mask = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < RD-1; i++) begin
            step();
            checks++; if (anode_n !== 8'hFF) begin failures++; $display("FAIL first_dark cyc=%0d got=%h exp=ff", i+2, anode_n); end
        end
        step();
        checks++; if (anode_n !== 8'hFE || digit_out !== 4'd1 || digit_idx !== 3'd0) begin
            failures++; $display("FAIL first_lit an=%h dig=%0d idx=%0d exp fe/1/0", anode_n, digit_out, digit_idx);
        end
        for (int i = 0; i < 2*N*RD + RD; i++) begin
            step();
            checks++;
            if ({anode_n, digit_out, digit_idx, team_view} !== {m_an, m_dig, m_idx, m_tv}) begin
                failures++;
                $display("FAIL scan_model t=%0t an=%h dig=%0d idx=%0d tv=%b exp an=%h dig=%0d idx=%0d tv=%b",
                         $time, anode_n, digit_out, digit_idx, team_view, m_an, m_dig, m_idx, m_tv);
            end
            if (m_ticked && m_idx == 3'd6) begin
                checks++; if (digit_out !== 4'd1) begin failures++; $display("FAIL slot6_glyph got=%0d exp=1", digit_out); end
            end
            if (m_ticked && m_idx == 3'd7) begin
                checks++; if (digit_out !== 4'd15) begin failures++; $display("FAIL slot7_glyph got=%0d exp=15", digit_out); end
            end
        end
    endtask

    task automatic test_blank();
        blank_mask = 8'h04;
        for (int i = 0; i < 2*N*RD; i++) begin
            step();
            checks++;
            if ({anode_n, digit_out, digit_idx, team_view} !== {m_an, m_dig, m_idx, m_tv}) begin
                failures++;
                $display("FAIL blank_model t=%0t an=%h dig=%0d idx=%0d exp an=%h dig=%0d idx=%0d",
                         $time, anode_n, digit_out, digit_idx, m_an, m_dig, m_idx);
            end
            if (m_ticked && m_idx == 3'd2) begin
                checks++;
                if (anode_n !== 8'hFF || digit_out !== 4'd3 || digit_idx !== 3'd2) begin
                    failures++; $display("FAIL blank_slot2 an=%h dig=%0d idx=%0d exp ff/3/2", anode_n, digit_out, digit_idx);
                end
            end
        end
        blank_mask = '0;
    endtask

    task automatic test_blink();
        logic [4:0] lit;
        lit = '0;
        blink_mask = 8'h01;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5*N*RD; i++) begin
            step();
            checks++;
            if ({anode_n, digit_out, digit_idx, team_view} !== {m_an, m_dig, m_idx, m_tv}) begin
                failures++;
                $display("FAIL blink_model t=%0t an=%h idx=%0d exp an=%h idx=%0d", $time, anode_n, digit_idx, m_an, m_idx);
            end
            if (m_ticked && m_idx == 3'd0) lit[m_t / N] = (anode_n[0] == 1'b0);
        end
        checks++; if (lit !== 5'b10011) begin failures++; $display("FAIL blink_frames got=%b exp=10011", lit); end
        blink_mask = '0;
    endtask

    task automatic test_team();
        // {update, team_sw, inning_over, game_over, winner, exp_view, exp_glyph}
        logic [9:0] tbl [6];
        logic [9:0] row;
        logic       found;
        tbl[0] = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2};
        tbl[1] = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[2] = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2};
        tbl[3] = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1};
        tbl[4] = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1};
        tbl[5] = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1};
        for (int r = 0; r < 6; r++) begin
            row = tbl[r];
            {inning_over, game_over, winner} = row[7:5];
            update  = row[9];
            team_sw = row[8];
            step();
            update  = 1'b0;
            team_sw = 1'b0;
            checks++; if (team_view !== row[4]) begin failures++; $display("FAIL team_view row=%0d got=%b exp=%b", r, team_view, row[4]); end
            found = 1'b0;
            for (int i = 0; i < 2*N*RD && !found; i++) begin
                step();
                checks++;
                if ({anode_n, digit_out, digit_idx, team_view} !== {m_an, m_dig, m_idx, m_tv}) begin
                    failures++;
                    $display("FAIL team_model row=%0d an=%h dig=%0d idx=%0d tv=%b exp an=%h dig=%0d idx=%0d tv=%b",
                             r, anode_n, digit_out, digit_idx, team_view, m_an, m_dig, m_idx, m_tv);
                end
                if (m_ticked && m_idx == 3'd6) begin
                    found = 1'b1;
                    checks++; if (digit_out !== row[3:0]) begin failures++; $display("FAIL team_glyph row=%0d got=%0d exp=%0d", r, digit_out, row[3:0]); end
                end
            end
            if (!found) begin checks++; failures++; $display("FAIL team_wait row=%0d slot 6 never visited", r); end
        end
    endtask

    task automatic test_simul_strobes();
        logic found;
        inning_over = 1'b1;
        game_over   = 1'b0;
        update      = 1'b1;
        team_sw     = 1'b1;
        step();
        update  = 1'b0;
        team_sw = 1'b0;
        checks++; if (team_view !== 1'b0) begin failures++; $display("FAIL simul_view got=%b exp=0", team_view); end
        found = 1'b0;
        for (int i = 0; i < 2*N*RD && !found; i++) begin
            step();
            if (m_ticked && m_idx == 3'd6) begin
                found = 1'b1;
                checks++; if (digit_out !== 4'd1) begin failures++; $display("FAIL simul_glyph got=%0d exp=1", digit_out); end
            end
        end
        if (!found) begin checks++; failures++; $display("FAIL simul_wait slot 6 never visited"); end
    endtask

    task automatic test_reset_midscan();
        logic found;
        team_sw = 1'b1;
        step();
        team_sw = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2*N*RD && !found; i++) begin
            step();
            if (m_ticked && m_idx == 3'd5) found = 1'b1;
        end
        checks++;
        if (!found || anode_n !== 8'hDF || team_view !== 1'b1) begin
            failures++; $display("FAIL midscan_setup found=%b an=%h tv=%b exp 1/df/1", found, anode_n, team_view);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (anode_n !== 8'hFF || team_view !== 1'b0 || digit_out !== 4'd0 || digit_idx !== 3'd0) begin
            failures++; $display("FAIL midscan_reset an=%h tv=%b dig=%0d idx=%0d exp ff/0/0/0", anode_n, team_view, digit_out, digit_idx);
        end
        for (int i = 0; i < RD-1; i++) begin
            step();
            checks++; if (anode_n !== 8'hFF) begin failures++; $display("FAIL midscan_dark cyc=%0d got=%h exp=ff", i, anode_n); end
        end
        step();
        checks++;
        if (anode_n !== 8'hFE || digit_idx !== 3'd0 || digit_out !== 4'd1) begin
            failures++; $display("FAIL midscan_restart an=%h idx=%0d dig=%0d exp fe/0/1", anode_n, digit_idx, digit_out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            digits_in = $urandom;
            if ($urandom_range(0, 5) == 0) blank_mask = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 5) == 0) blink_mask = 8'($urandom);
            inning_over = 1'($urandom);
            game_over   = 1'($urandom);
            winner      = 1'($urandom);
            update      = ($urandom_range(0, 6) == 0);
            team_sw     = ($urandom_range(0, 6) == 0);
            step();
            checks++;
            if ({anode_n, digit_out, digit_idx, team_view} !== {m_an, m_dig, m_idx, m_tv}) begin
                failures++;
                $display("FAIL random_model i=%0d an=%h dig=%0d idx=%0d tv=%b exp an=%h dig=%0d idx=%0d tv=%b",
                         i, anode_n, digit_out, digit_idx, team_view, m_an, m_dig, m_idx, m_tv);
            end
        end
        update  = 1'b0;
        team_sw = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_blank();
        test_blink();
        test_team();
        test_simul_strobes();
        test_reset_midscan();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
